reg_bus_arb: RTL and testbench
==============================

REG_BUS_ARB -- requirements
Module: reg_bus_arb

Interface
REQ-001 Parameter: ADDR_W, 7, register address width.
REQ-002 Parameter: DATA_W, 32, register data width.
REQ-003 Parameter: MAX_LOCK, 8, maximum back-to-back transfers one master may hold under lock (range 1..255).
REQ-004 clk  in  1  system clock (48 MHz domain); all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mN_req  in  1  master N (N=0 SPI-slave host, N=1 RISC-V) transfer request; level, held until grant.
REQ-007 mN_we  in  1  master N write (1) / read (0); stable while mN_req high.
REQ-008 mN_addr  in  ADDR_W  master N register address; stable while mN_req high.
REQ-009 mN_wdat  in  DATA_W  master N write data; stable while mN_req high.
REQ-010 mN_lock  in  1  master N keeps ownership for next transfer (present only with REG_ARB_LOCK_EN).
REQ-011 mN_gnt  out  1  one-cycle pulse: master N request accepted this cycle.
REQ-012 mN_rdat  out  DATA_W  master N read data, valid when mN_rvalid.
REQ-013 mN_rvalid  out  1  one-cycle pulse, read data available.
REQ-014 s_we / s_re  out  1 each  shared register bank write/read strobe.
REQ-015 s_addr  out  ADDR_W; s_wdat  out  DATA_W  shared bank address/write data.
REQ-016 s_rdat  in  DATA_W  combinational read data from bank for s_addr.

Function
REQ-017 FSM states: IDLE, XFER; all outputs registered or decoded from registered state only.
REQ-018 IDLE: if any mN_req, select winner, load s_addr/s_wdat/s_we/s_re from winner, go XFER next cycle; else stay IDLE, all strobes 0.
REQ-019 XFER lasts exactly one cycle: exactly one of s_we/s_re high, mN_gnt high for winner only.
REQ-020 On XFER read, s_rdat captured into winner mN_rdat at end of XFER; mN_rvalid pulses the following cycle; writes produce no rvalid.
REQ-021 Latency: req high in IDLE -> gnt 1 cycle later -> rvalid 2 cycles later; unlocked throughput one transfer per 2 cycles.
REQ-022 Arbitration: round-robin pointer; simultaneous requests -> pointer master wins; after every grant pointer points to the non-winner.
REQ-023 Single requester always wins regardless of pointer.
REQ-024 Request dropped before grant is not granted; requests sampled only in IDLE (or lock decision in XFER).
REQ-025 mN_rdat holds last captured value until next read by master N.
REQ-026 No strobe, gnt or rvalid asserted for more than one consecutive cycle except under lock.

Reset
REQ-027 During reset: state IDLE, pointer = master 0, lock counter 0, all strobes/gnt/rvalid 0, s_addr/s_wdat/mN_rdat 0.
REQ-028 Reset asserted mid-XFER: strobes, gnt and pending rvalid deasserted the next cycle; in-flight transfer discarded, no rvalid ever issued for it.

Configuration
REQ-029 Macro REG_ARB_LOCK_EN: defined -> mN_lock ports exist; in XFER, if winner has mN_lock and mN_req high and lock count < MAX_LOCK-1, next cycle is XFER for same master (1 transfer/cycle), counter increments.
REQ-030 Lock count reaching MAX_LOCK-1, or lock/req dropped: return to IDLE, counter cleared, pointer to other master.
REQ-031 Undefined: no mN_lock ports, XFER always returns to IDLE, behaviour otherwise identical.

Structure
REQ-032 Package reg_arb_pkg: FSM state enum, master index constants (M_SPI=0, M_RISC=1), default widths.
REQ-033 Sub-module rr_pick2: 2-way round-robin picker (req[1:0], ptr -> onehot winner), combinational.

Verification
REQ-034 Reset, m0 read addr 0x00, s_rdat=0xB00F0000 -> m0_gnt at cycle+1, m0_rvalid with m0_rdat=0xB00F0000 at cycle+2.
REQ-035 m0 and m1 write same cycle from reset -> m0 granted first (s_addr=m0_addr), m1 granted 2 cycles later; pointer alternates over 4 contested rounds.
REQ-036 m1 write addr 0x02 data 0x12345678 -> s_we one cycle, s_wdat=0x12345678, no m1_rvalid.
REQ-037 Reset asserted during XFER of m1 read -> no m1_rvalid, all strobes 0 next cycle, next request granted to m0 on simultaneous request.
REQ-038 REG_ARB_LOCK_EN, MAX_LOCK=4, m0 locked with m1 requesting -> 4 consecutive m0 XFER cycles, then IDLE, then m1 granted.
REQ-039 Toggle m1_req for one cycle while m0 in XFER -> m1 never granted.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-master register-bus arbiter.
package reg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int unsigned M_SPI  = 0;
  localparam int unsigned M_RISC = 1;

  localparam int unsigned DEFAULT_ADDR_W   = 7;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_MAX_LOCK = 8;

  // Lock counter width covers MAX_LOCK up to 255.
  localparam int unsigned LOCK_W = 8;

endpackage

// File: rtl/reg_bus_arb_if.sv
// Bundle of both master request channels and the shared bank port.
// The mN_lock signals exist only when REG_ARB_LOCK_EN is defined.
interface reg_bus_arb_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

  logic              m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdat, m0_rdat;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdat, m1_rdat;
`ifdef REG_ARB_LOCK_EN
  logic              m0_lock, m1_lock;
`endif
  logic              s_we, s_re;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdat, s_rdat;

  // Requesters plus bank model side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdat,
    output m1_req, m1_we, m1_addr, m1_wdat,
`ifdef REG_ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    input  m0_gnt, m0_rdat, m0_rvalid, m1_gnt, m1_rdat, m1_rvalid,
    input  s_we, s_re, s_addr, s_wdat,
    output s_rdat
  );

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdat,
    input  m1_req, m1_we, m1_addr, m1_wdat,
`ifdef REG_ARB_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    output m0_gnt, m0_rdat, m0_rvalid, m1_gnt, m1_rdat, m1_rvalid,
    output s_we, s_re, s_addr, s_wdat,
    input  s_rdat
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot winner from request pair and priority pointer.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_win_c
);

  always_comb begin
    o_win_c = i_req;
    if (&i_req) o_win_c = i_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/reg_bus_arb.sv
// Two-master register-bus arbiter: round-robin IDLE/XFER handshake onto a shared bank.
// Same-master back-to-back bursting is enabled by defining REG_ARB_LOCK_EN.
module reg_bus_arb
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned MAX_LOCK = DEFAULT_MAX_LOCK
) (
  input logic          clk,
  input logic          reset,
  reg_bus_arb_if.slave io_bus
);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  arb_state_e        r_state;
  logic              r_ptr, r_win, r_s_we, r_s_re;
  logic [1:0]        r_gnt, r_rvalid;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdat, r_rdat0, r_rdat1;

  logic [1:0]        w_req, w_pick;
  logic              w_sel, w_sel_we, w_lock_hold, w_lock_ok;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdat;

  assign w_req = {io_bus.m1_req, io_bus.m0_req};

  rr_pick2 u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_win_c (w_pick)
  );

  // In IDLE the picker chooses; during a locked burst the current owner is reloaded.
  assign w_sel      = (r_state == IDLE) ? w_pick[1] : r_win;
  assign w_sel_we   = w_sel ? io_bus.m1_we   : io_bus.m0_we;
  assign w_sel_addr = w_sel ? io_bus.m1_addr : io_bus.m0_addr;
  assign w_sel_wdat = w_sel ? io_bus.m1_wdat : io_bus.m0_wdat;

`ifdef REG_ARB_LOCK_EN
  assign w_lock_hold = r_win ? (io_bus.m1_lock && io_bus.m1_req)
                             : (io_bus.m0_lock && io_bus.m0_req);
`else
  assign w_lock_hold = 1'b0;
`endif
  assign w_lock_ok = w_lock_hold && (r_lock_cnt < LOCK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= 1'(M_SPI);
      r_win      <= 1'b0;
      r_lock_cnt <= '0;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_s_we     <= 1'b0;
      r_s_re     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdat   <= '0;
      r_rdat0    <= '0;
      r_rdat1    <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state  <= XFER;
            r_win    <= w_pick[1];
            r_ptr    <= ~w_pick[1];
            r_gnt    <= w_pick;
            r_s_we   <= w_sel_we;
            r_s_re   <= ~w_sel_we;
            r_s_addr <= w_sel_addr;
            r_s_wdat <= w_sel_wdat;
          end else begin
            r_s_we <= 1'b0;
            r_s_re <= 1'b0;
          end
        end
        XFER: begin
          // Bank read data is combinational on s_addr, so capture at the end of XFER.
          if (r_s_re) begin
            if (r_win) r_rdat1 <= io_bus.s_rdat;
            else       r_rdat0 <= io_bus.s_rdat;
            r_rvalid <= r_win ? 2'b10 : 2'b01;
          end
          if (w_lock_ok) begin
            r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
            r_gnt      <= r_win ? 2'b10 : 2'b01;
            r_s_we     <= w_sel_we;
            r_s_re     <= ~w_sel_we;
            r_s_addr   <= w_sel_addr;
            r_s_wdat   <= w_sel_wdat;
          end else begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_s_we     <= 1'b0;
            r_s_re     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.m0_gnt    = r_gnt[0];
  assign io_bus.m1_gnt    = r_gnt[1];
  assign io_bus.m0_rvalid = r_rvalid[0];
  assign io_bus.m1_rvalid = r_rvalid[1];
  assign io_bus.m0_rdat   = r_rdat0;
  assign io_bus.m1_rdat   = r_rdat1;
  assign io_bus.s_we      = r_s_we;
  assign io_bus.s_re      = r_s_re;
  assign io_bus.s_addr    = r_s_addr;
  assign io_bus.s_wdat    = r_s_wdat;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Self-checking bench for reg_bus_arb: directed scenarios plus randomized traffic vs a transaction model.
module tb_reg_bus_arb;
  import reg_arb_pkg::*;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_LOCK = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reg_bus_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(int i);
    return 32'hB00F0000 ^ (32'(i) * 32'h01030507);
  endfunction

  // Register bank: combinational read, write on s_we, reloaded on reset.
  logic [DATA_W-1:0] mem [128];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= pattern(i);
    end else if (bus.s_we) begin
      mem[bus.s_addr] <= bus.s_wdat;
    end
  end
  assign bus.s_rdat = mem[bus.s_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdat = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdat = '0;
`ifdef REG_ARB_LOCK_EN
    bus.m0_lock = 1'b0; bus.m1_lock = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.s_we, bus.s_re} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 000000",
               {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.s_we, bus.s_re});
    end
    checks++;
    if (bus.s_addr !== '0 || bus.s_wdat !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr %h wdat %h expected 0 0", bus.s_addr, bus.s_wdat);
    end
    checks++;
    if (bus.m0_rdat !== '0 || bus.m1_rdat !== '0) begin
      errors++;
      $display("FAIL reset_rdat: got %h %h expected 0 0", bus.m0_rdat, bus.m1_rdat);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 7'h00;
    step();
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01 || bus.m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_gnt: got gnt %b rvalid %b expected 01 0", {bus.m1_gnt, bus.m0_gnt}, bus.m0_rvalid);
    end
    checks++;
    if ({bus.s_we, bus.s_re} !== 2'b01 || bus.s_addr !== 7'h00) begin
      errors++;
      $display("FAIL read_strobe: got we/re %b addr %h expected 01 00", {bus.s_we, bus.s_re}, bus.s_addr);
    end
    bus.m0_req = 1'b0;
    step();
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdat !== 32'hB00F0000) begin
      errors++;
      $display("FAIL read_rvalid: got %b %h expected 1 b00f0000", bus.m0_rvalid, bus.m0_rdat);
    end
    checks++;
    if (bus.m0_gnt !== 1'b0 || bus.s_re !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse: got gnt %b s_re %b expected 0 0", bus.m0_gnt, bus.s_re);
    end
    step();
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdat !== 32'hB00F0000) begin
      errors++;
      $display("FAIL read_hold: got %b %h expected 0 b00f0000", bus.m0_rvalid, bus.m0_rdat);
    end
  endtask

  task automatic test_contention();
    logic [6:0]  a [2];
    logic [31:0] d [2];
    int w;
    apply_reset();
    a[0] = 7'h10; a[1] = 7'h20; d[0] = 32'hA0A0_0000; d[1] = 32'hA1A1_0000;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = a[0]; bus.m0_wdat = d[0];
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = a[1]; bus.m1_wdat = d[1];
    for (int r = 0; r < 4; r++) begin
      w = r % 2;
      step();
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_gnt round %0d: got %b expected master %0d", r, {bus.m1_gnt, bus.m0_gnt}, w);
      end
      checks++;
      if (bus.s_we !== 1'b1 || bus.s_addr !== a[w] || bus.s_wdat !== d[w]) begin
        errors++;
        $display("FAIL rr_bus round %0d: got we %b addr %h wdat %h expected 1 %h %h",
                 r, bus.s_we, bus.s_addr, bus.s_wdat, a[w], d[w]);
      end
      a[w] = a[w] + 7'd1; d[w] = d[w] + 32'd1;
      if (w == 0) begin bus.m0_addr = a[0]; bus.m0_wdat = d[0]; end
      else        begin bus.m1_addr = a[1]; bus.m1_wdat = d[1]; end
      step();
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt, bus.s_we, bus.s_re} !== 4'b0) begin
        errors++;
        $display("FAIL rr_gap round %0d: got %b expected 0000", r, {bus.m1_gnt, bus.m0_gnt, bus.s_we, bus.s_re});
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write();
    apply_reset();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 7'h02; bus.m1_wdat = 32'h12345678;
    step();
    checks++;
    if (bus.m1_gnt !== 1'b1 || bus.s_we !== 1'b1 || bus.s_re !== 1'b0 ||
        bus.s_addr !== 7'h02 || bus.s_wdat !== 32'h12345678) begin
      errors++;
      $display("FAIL write_xfer: got gnt %b we %b re %b addr %h wdat %h expected 1 1 0 02 12345678",
               bus.m1_gnt, bus.s_we, bus.s_re, bus.s_addr, bus.s_wdat);
    end
    bus.m1_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (bus.s_we !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL write_norv cycle %0d: got we %b rvalid %b expected 0 0", k, bus.s_we, bus.m1_rvalid);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 7'h05;
    step();
    checks++;
    if (bus.m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmid_gnt: got %b expected 1", bus.m1_gnt);
    end
    bus.m1_req = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.s_we, bus.s_re, bus.m0_rvalid, bus.m1_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL rmid_clear: got %b expected 000000",
               {bus.m0_gnt, bus.m1_gnt, bus.s_we, bus.s_re, bus.m0_rvalid, bus.m1_rvalid});
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.m1_rvalid !== 1'b0 || bus.m1_rdat !== '0) begin
      errors++;
      $display("FAIL rmid_norv: got rvalid %b rdat %h expected 0 0", bus.m1_rvalid, bus.m1_rdat);
    end
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 7'h01;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 7'h03;
    step();
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_ptr: got %b expected 01", {bus.m1_gnt, bus.m0_gnt});
    end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_toggle();
    apply_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 7'h03;
    step();
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL toggle_m0: got %b expected 1", bus.m0_gnt);
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 7'h09; bus.m1_wdat = 32'hDEAD0009;
    step();
    bus.m1_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.m1_gnt !== 1'b0 || bus.s_we !== 1'b0) begin
        errors++;
        $display("FAIL toggle_m1 cycle %0d: got gnt %b we %b expected 0 0", k, bus.m1_gnt, bus.s_we);
      end
    end
  endtask

`ifdef REG_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 7'h04;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 7'h06; bus.m1_wdat = 32'h0000_0606;
    for (int k = 0; k < int'(MAX_LOCK); k++) begin
      step();
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01 || bus.s_re !== 1'b1 || bus.m0_rvalid !== (k > 0)) begin
        errors++;
        $display("FAIL lock_burst cycle %0d: got gnt %b re %b rvalid %b expected 01 1 %0d",
                 k, {bus.m1_gnt, bus.m0_gnt}, bus.s_re, bus.m0_rvalid, k > 0);
      end
    end
    step();
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.s_we, bus.s_re} !== 4'b0 || bus.m0_rdat !== pattern(4)) begin
      errors++;
      $display("FAIL lock_idle: got %b rdat %h expected 0000 %h",
               {bus.m1_gnt, bus.m0_gnt, bus.s_we, bus.s_re}, bus.m0_rdat, pattern(4));
    end
    step();
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10 || bus.s_we !== 1'b1) begin
      errors++;
      $display("FAIL lock_handover: got gnt %b we %b expected 10 1", {bus.m1_gnt, bus.m0_gnt}, bus.s_we);
    end
    idle_inputs();
    step(); step();
  endtask
`endif

  // Transaction-level model: one transfer occupies the bus for one cycle after each grant.
  task automatic test_random();
    logic [31:0] model_mem [128];
    logic        rq [2], rwe [2];
    logic [6:0]  radr [2];
    logic [31:0] rdt [2], last [2];
    int          gap [2];
    int          ptr, t_win;
    logic        t_we;
    logic [6:0]  t_addr;
    logic [31:0] t_wdat;
    logic [1:0]  exp_gnt, exp_rv, nxt_gnt, nxt_rv, exp_s;
    apply_reset();
    for (int i = 0; i < 128; i++) model_mem[i] = pattern(i);
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; rwe[m] = 1'b0; radr[m] = '0; rdt[m] = '0; last[m] = '0; gap[m] = 0;
    end
    ptr = 0; t_win = 0; t_we = 1'b0; t_addr = '0; t_wdat = '0;
    exp_gnt = '0; exp_rv = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_gnt) begin
        errors++;
        $display("FAIL rnd_gnt cycle %0d: got %b expected %b", cyc, {bus.m1_gnt, bus.m0_gnt}, exp_gnt);
      end
      checks++;
      if ({bus.m1_rvalid, bus.m0_rvalid} !== exp_rv) begin
        errors++;
        $display("FAIL rnd_rvalid cycle %0d: got %b expected %b", cyc, {bus.m1_rvalid, bus.m0_rvalid}, exp_rv);
      end
      checks++;
      if (bus.m0_rdat !== last[0] || bus.m1_rdat !== last[1]) begin
        errors++;
        $display("FAIL rnd_rdat cycle %0d: got %h %h expected %h %h",
                 cyc, bus.m0_rdat, bus.m1_rdat, last[0], last[1]);
      end
      exp_s = (exp_gnt != 2'b00) ? (t_we ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({bus.s_we, bus.s_re} !== exp_s) begin
        errors++;
        $display("FAIL rnd_strobe cycle %0d: got %b expected %b", cyc, {bus.s_we, bus.s_re}, exp_s);
      end
      if (exp_gnt != 2'b00) begin
        checks++;
        if (bus.s_addr !== t_addr || (t_we && bus.s_wdat !== t_wdat)) begin
          errors++;
          $display("FAIL rnd_bus cycle %0d: got addr %h wdat %h expected %h %h",
                   cyc, bus.s_addr, bus.s_wdat, t_addr, t_wdat);
        end
      end
      // Masters: release after grant, occasionally abandon, otherwise post new work.
      for (int m = 0; m < 2; m++) begin
        if (exp_gnt[m]) begin
          rq[m] = 1'b0; gap[m] = int'($urandom_range(0, 2));
        end else if (rq[m]) begin
          if ($urandom_range(0, 9) == 0) rq[m] = 1'b0;
        end else if (gap[m] > 0) begin
          gap[m]--;
        end else if ($urandom_range(0, 1) == 1) begin
          rq[m] = 1'b1; rwe[m] = 1'($urandom_range(0, 1));
          radr[m] = 7'($urandom_range(0, 15)); rdt[m] = $urandom;
        end
      end
      bus.m0_req = rq[0]; bus.m0_we = rwe[0]; bus.m0_addr = radr[0]; bus.m0_wdat = rdt[0];
      bus.m1_req = rq[1]; bus.m1_we = rwe[1]; bus.m1_addr = radr[1]; bus.m1_wdat = rdt[1];
      nxt_gnt = '0; nxt_rv = '0;
      if (exp_gnt != 2'b00) begin
        if (t_we) model_mem[t_addr] = t_wdat;
        else begin nxt_rv[t_win] = 1'b1; last[t_win] = model_mem[t_addr]; end
      end else if (rq[0] || rq[1]) begin
        t_win = (rq[0] && rq[1]) ? ptr : (rq[1] ? 1 : 0);
        ptr = 1 - t_win;
        nxt_gnt[t_win] = 1'b1;
        t_we = rwe[t_win]; t_addr = radr[t_win]; t_wdat = rdt[t_win];
      end
      exp_gnt = nxt_gnt; exp_rv = nxt_rv;
    end
    idle_inputs();
    step(); step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_reset_mid();
    test_toggle();
`ifdef REG_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
